// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage branch hazard controller:
// register index width, FSM state encoding and load-to-branch stall length.
package branch_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // A load in EX feeding a branch in ID must wait until the load reaches
  // MEM/WB, which takes this many stall cycles.
  localparam int unsigned LOAD_BRANCH_STALL = 2;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/branch_hazard_ctrl_match.sv
// Producer match for one ID source register against the EX and MEM stages.
// Pure combinational; x0 never matches.
module hazard_match #(
  parameter int unsigned REG_ADDR_W = branch_hazard_ctrl_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] idex_rd_i,
  input  logic                  idex_reg_write_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic                  exmem_reg_write_i,
  output logic                  match_ex_o,
  output logic                  match_mem_o
);

  assign match_ex_o  = idex_reg_write_i  && (idex_rd_i  != '0) && (idex_rd_i  == rs_i);
  assign match_mem_o = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Stall/flush controller for branches resolved in ID.
// Stalls while a branch operand is not yet forwardable, flushes IF/ID on a
// taken branch, and runs a load-use stall to completion via a RUN/STALL FSM.
// Optional saturating performance counters: define BRANCH_HAZARD_PERF_EN.
module branch_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = branch_hazard_ctrl_pkg::REG_ADDR_W,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  branch,
  input  logic                  branch_taken,
  input  logic [REG_ADDR_W-1:0] IFID_rs1,
  input  logic [REG_ADDR_W-1:0] IFID_rs2,
  input  logic [REG_ADDR_W-1:0] IDEX_rd,
  input  logic                  IDEX_reg_write,
  input  logic                  IDEX_mem_read,
  input  logic [REG_ADDR_W-1:0] EXMEM_rd,
  input  logic                  EXMEM_reg_write,
  input  logic                  EXMEM_mem_read,
  input  logic                  pipe_kill,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  stalling
`ifdef BRANCH_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_stall_cycles,
  output logic [CNT_W-1:0]      perf_branch_flushes
`endif
);

  import branch_hazard_ctrl_pkg::*;

  state_e state_q, state_d;
  logic   stall;
  logic   rs1_ex, rs1_mem, rs2_ex, rs2_mem;
  logic   any_ex, any_mem;
  logic   hz_ld_ex, hz_alu_ex, hz_ld_mem;

  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs1 (
    .rs_i              (IFID_rs1),
    .idex_rd_i         (IDEX_rd),
    .idex_reg_write_i  (IDEX_reg_write),
    .exmem_rd_i        (EXMEM_rd),
    .exmem_reg_write_i (EXMEM_reg_write),
    .match_ex_o        (rs1_ex),
    .match_mem_o       (rs1_mem)
  );

  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs2 (
    .rs_i              (IFID_rs2),
    .idex_rd_i         (IDEX_rd),
    .idex_reg_write_i  (IDEX_reg_write),
    .exmem_rd_i        (EXMEM_rd),
    .exmem_reg_write_i (EXMEM_reg_write),
    .match_ex_o        (rs2_ex),
    .match_mem_o       (rs2_mem)
  );

  // rs1==rs2 collapses naturally: both matches OR into one hazard.
  assign any_ex    = rs1_ex  | rs2_ex;
  assign any_mem   = rs1_mem | rs2_mem;
  assign hz_ld_ex  = branch & any_ex  &  IDEX_mem_read;
  assign hz_alu_ex = branch & any_ex  & ~IDEX_mem_read;
  assign hz_ld_mem = branch & any_mem &  EXMEM_mem_read;

  // FSM state register; STALL covers the second cycle of a load-in-EX stall.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state and stall decision; pipe_kill overrides everything.
  // NOTE: defaults are assigned first so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      RUN: begin
        stall   = hz_ld_ex | hz_alu_ex | hz_ld_mem;
        state_d = hz_ld_ex ? STALL : RUN;
      end
      STALL: begin
        // Committed to the second load-use cycle; inputs are not re-read.
        stall   = 1'b1;
        state_d = RUN;
      end
      default: begin
        stall   = 1'b0;
        state_d = RUN;
      end
    endcase
    if (pipe_kill) begin
      stall   = 1'b0;
      state_d = RUN;
    end
  end

  assign pc_write    = ~stall;
  assign ifid_write  = ~stall;
  assign idex_bubble = stall;
  assign ifid_flush  = pipe_kill | (branch & branch_taken & ~stall);
  assign stalling    = (state_q == STALL);

`ifdef BRANCH_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating increments: hold at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifid_flush && !pipe_kill && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cycles   = stall_cnt_q;
  assign perf_branch_flushes = flush_cnt_q;
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_perf_shape;
  assign unused_perf_shape = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: a cycle-level model counting
// owed stall cycles, checked every cycle, plus directed literal expectations.
module tb_branch_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          branch, branch_taken, pipe_kill;
  logic [AW-1:0] IFID_rs1, IFID_rs2, IDEX_rd, EXMEM_rd;
  logic          IDEX_reg_write, IDEX_mem_read, EXMEM_reg_write, EXMEM_mem_read;
  logic          pc_write, ifid_write, idex_bubble, ifid_flush, stalling;
`ifdef BRANCH_HAZARD_PERF_EN
  logic [CW-1:0] perf_stall_cycles, perf_branch_flushes;
  int            m_stall_cnt, m_flush_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  branch_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .branch          (branch),
    .branch_taken    (branch_taken),
    .IFID_rs1        (IFID_rs1),
    .IFID_rs2        (IFID_rs2),
    .IDEX_rd         (IDEX_rd),
    .IDEX_reg_write  (IDEX_reg_write),
    .IDEX_mem_read   (IDEX_mem_read),
    .EXMEM_rd        (EXMEM_rd),
    .EXMEM_reg_write (EXMEM_reg_write),
    .EXMEM_mem_read  (EXMEM_mem_read),
    .pipe_kill       (pipe_kill),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .idex_bubble     (idex_bubble),
    .ifid_flush      (ifid_flush),
    .stalling        (stalling)
`ifdef BRANCH_HAZARD_PERF_EN
    ,
    .perf_stall_cycles   (perf_stall_cycles),
    .perf_branch_flushes (perf_branch_flushes)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Stall cycles a branch needs right now, from the hazard rules.
  function automatic int need_now();
    int n = 0;
    logic [AW-1:0] srcs [2];
    if (!branch) return 0;
    srcs[0] = IFID_rs1;
    srcs[1] = IFID_rs2;
    for (int i = 0; i < 2; i++) begin
      if (IDEX_reg_write && IDEX_rd != 0 && IDEX_rd == srcs[i]) begin
        if (IDEX_mem_read) n = 2;
        else if (n < 1)    n = 1;
      end
      if (EXMEM_reg_write && EXMEM_rd != 0 && EXMEM_rd == srcs[i] && EXMEM_mem_read && n < 1)
        n = 1;
    end
    return n;
  endfunction

  int pend = 0;  // committed stall cycles still owed after the current one

  function automatic bit m_stall();
    if (pipe_kill) return 1'b0;
    if (pend > 0)  return 1'b1;
    return need_now() > 0;
  endfunction

  function automatic bit m_flush();
    return pipe_kill | (branch & branch_taken & !m_stall());
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 0;
`ifdef BRANCH_HAZARD_PERF_EN
      m_stall_cnt = 0;
      m_flush_cnt = 0;
`endif
    end else begin
`ifdef BRANCH_HAZARD_PERF_EN
      if (m_stall() && m_stall_cnt < (1 << CW) - 1) m_stall_cnt++;
      if (m_flush() && !pipe_kill && m_flush_cnt < (1 << CW) - 1) m_flush_cnt++;
`endif
      if (pipe_kill)     pend = 0;
      else if (pend > 0) pend = pend - 1;
      else               pend = (need_now() > 0) ? need_now() - 1 : 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("m.pc_write",    32'(pc_write),    32'(!m_stall()));
      check("m.ifid_write",  32'(ifid_write),  32'(!m_stall()));
      check("m.idex_bubble", 32'(idex_bubble), 32'(m_stall()));
      check("m.ifid_flush",  32'(ifid_flush),  32'(m_flush()));
      check("m.stalling",    32'(stalling),    32'(pend > 0));
`ifdef BRANCH_HAZARD_PERF_EN
      check("m.perf_stall",  32'(perf_stall_cycles),   32'(m_stall_cnt));
      check("m.perf_flush",  32'(perf_branch_flushes), 32'(m_flush_cnt));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clr();
    branch = 0; branch_taken = 0; pipe_kill = 0;
    IFID_rs1 = 0; IFID_rs2 = 0; IDEX_rd = 0; EXMEM_rd = 0;
    IDEX_reg_write = 0; IDEX_mem_read = 0; EXMEM_reg_write = 0; EXMEM_mem_read = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Literal expectations for the current cycle.
  task automatic expect_out(input string tag, input bit pcw, input bit flush, input bit stl);
    check({tag, ".pc_write"},    32'(pc_write),    32'(pcw));
    check({tag, ".ifid_write"},  32'(ifid_write),  32'(pcw));
    check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(!pcw));
    check({tag, ".ifid_flush"},  32'(ifid_flush),  32'(flush));
    check({tag, ".stalling"},    32'(stalling),    32'(stl));
  endtask

  task automatic load_ex(input logic [AW-1:0] rd);
    IDEX_rd = rd; IDEX_reg_write = 1; IDEX_mem_read = 1;
  endtask

  initial begin
    clr();
    rst_n = 0;
    #12;
    expect_out("reset", 1, 0, 0);
    tick();
    rst_n = 1;

    // ALU producer in EX: one stall, then forwardable from EX/MEM.
    branch = 1; IFID_rs1 = 5; IDEX_rd = 5; IDEX_reg_write = 1;
    @(negedge clk); expect_out("alu.c1", 0, 0, 0); tick();
    IDEX_rd = 0; IDEX_reg_write = 0; EXMEM_rd = 5; EXMEM_reg_write = 1;
    @(negedge clk); expect_out("alu.c2", 1, 0, 0); tick();
    clr();

    // Load producer in EX on rs2: exactly two stall cycles.
    branch = 1; IFID_rs2 = 7; load_ex(7);
    @(negedge clk); expect_out("ld.c1", 0, 0, 0); tick();
    IDEX_rd = 0; IDEX_reg_write = 0; IDEX_mem_read = 0;
    @(negedge clk); expect_out("ld.c2", 0, 0, 1); tick();
    @(negedge clk); expect_out("ld.c3", 1, 0, 0); tick();
    clr();

    // Load in MEM: one stall.
    branch = 1; IFID_rs1 = 3; EXMEM_rd = 3; EXMEM_reg_write = 1; EXMEM_mem_read = 1;
    @(negedge clk); expect_out("ldmem.c1", 0, 0, 0); tick();
    clr(); branch = 1; IFID_rs1 = 3;
    @(negedge clk); expect_out("ldmem.c2", 1, 0, 0); tick();
    clr();

    // rd == 0 never hazards.
    branch = 1; IFID_rs1 = 0; load_ex(0);
    @(negedge clk); expect_out("rd0", 1, 0, 0); tick();
    clr();

    // branch = 0 never stalls even on matching indices.
    IFID_rs1 = 5; load_ex(5);
    @(negedge clk); expect_out("nobranch", 1, 0, 0); tick();
    clr();

    // Both operands hazarded, rs1==rs2 too: load in EX dominates (2 cycles).
    branch = 1; IFID_rs1 = 9; IFID_rs2 = 4; load_ex(9);
    EXMEM_rd = 4; EXMEM_reg_write = 1; EXMEM_mem_read = 1;
    @(negedge clk); expect_out("both.c1", 0, 0, 0); tick();
    clr(); branch = 1; IFID_rs1 = 6; IFID_rs2 = 6;
    @(negedge clk); expect_out("both.c2", 0, 0, 1); tick();
    IDEX_rd = 6; IDEX_reg_write = 1;
    @(negedge clk); expect_out("same.c1", 0, 0, 0); tick();
    clr();

    // Taken branch: flush when not stalling, no flush on stall cycles.
    branch = 1; branch_taken = 1;
    @(negedge clk); expect_out("taken", 1, 1, 0); tick();
    IFID_rs1 = 8; load_ex(8);
    @(negedge clk); expect_out("takenst.c1", 0, 0, 0); tick();
    IDEX_rd = 0; IDEX_reg_write = 0; IDEX_mem_read = 0;
    @(negedge clk); expect_out("takenst.c2", 0, 0, 1); tick();
    @(negedge clk); expect_out("takenst.c3", 1, 1, 0); tick();
    clr();

    // pipe_kill on the first cycle of a load stall: redirect wins.
    branch = 1; IFID_rs1 = 2; load_ex(2); pipe_kill = 1;
    @(negedge clk); expect_out("kill.c1", 1, 1, 0); tick();
    clr();
    @(negedge clk); expect_out("kill.c2", 1, 0, 0); tick();

    // pipe_kill during the STALL cycle also aborts it.
    branch = 1; IFID_rs1 = 2; load_ex(2);
    tick();
    clr(); pipe_kill = 1;
    @(negedge clk); expect_out("killst", 1, 1, 1); tick();
    clr();
    @(negedge clk); expect_out("killst.after", 1, 0, 0); tick();

    // Asynchronous reset in the middle of STALL.
    branch = 1; IFID_rs2 = 11; load_ex(11);
    tick();
    clr();
    @(negedge clk); expect_out("rst.pre", 0, 0, 1);
    #2 rst_n = 0;
    #1 expect_out("rst.mid", 1, 0, 0);
    tick();
    rst_n = 1;
    @(negedge clk); expect_out("rst.post", 1, 0, 0); tick();

`ifdef BRANCH_HAZARD_PERF_EN
    // Counters saturate at all-ones (CW bits) and never wrap.
    check("perf.stall.zero", 32'(perf_stall_cycles), 32'd0);
    branch = 1; IFID_rs1 = 5; IDEX_rd = 5; IDEX_reg_write = 1;
    for (int i = 0; i < 10; i++) tick();
    clr();
    @(negedge clk);
    check("perf.stall.sat", 32'(perf_stall_cycles), 32'd7);
    tick();
    branch = 1; branch_taken = 1;
    for (int i = 0; i < 10; i++) tick();
    clr();
    @(negedge clk);
    check("perf.flush.sat", 32'(perf_branch_flushes), 32'd7);
    tick();
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
